debug_ring_link: RTL and testbench
==================================

DEBUG_RING_LINK -- requirements
Module: debug_ring_link

Interface
REQ-001 Parameter DEPTH, default 4, flit slots per channel; legal values are powers of two, minimum 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 link_in  input  dii_flit[1:0]  per-channel upstream flit {valid, last, data[15:0]}, fed from a segment's ext_out.
REQ-005 link_in_ready  output  [1:0]  per-channel upstream ready.
REQ-006 link_out  output  dii_flit[1:0]  per-channel downstream flit, feeding the next segment's ext_in.
REQ-007 link_out_ready  input  [1:0]  per-channel downstream ready.
REQ-008 level  output  [1:0][$clog2(DEPTH):0]  per-channel flit occupancy.
REQ-009 pkt_pending  output  [1:0]  per-channel flag: at least one complete packet (flit with last=1) is stored.
REQ-010 Design is fixed: one clock; reset is synchronous and active-high.

Function
REQ-011 Channels 0 and 1 shall be independent, identical instances; no cross-channel interaction.
REQ-012 Each channel shall be a circular FIFO of DEPTH entries holding {last, data}, with write pointer, read pointer and a count.
REQ-013 Push when link_in[i].valid && link_in_ready[i]; pop when link_out[i].valid && link_out_ready[i].
REQ-014 link_in_ready[i] shall be a flop: next value = (count_next < DEPTH); no combinational path from link_out_ready to link_in_ready.
REQ-015 link_out[i].valid = (count != 0); link_out[i].last/data = head entry; valid shall not depend combinationally on link_in.
REQ-016 Latency: flit pushed at edge t is visible on link_out at the cycle after t (1-cycle minimum), order preserved, no flit dropped or duplicated.
REQ-017 Simultaneous push and pop shall leave count unchanged and advance both pointers.
REQ-018 Full (count == DEPTH): link_in_ready low; a pop then raises link_in_ready one cycle later.
REQ-019 Empty (count == 0): link_out valid low; a push into an empty FIFO shall not bypass storage.
REQ-020 Pointers shall wrap modulo DEPTH with no bubble at the wrap point.
REQ-021 level[i] = count; range 0..DEPTH.
REQ-022 A per-channel last-counter (width $clog2(DEPTH)+1) shall increment on push of a last=1 flit, decrement on pop of a last=1 flit, unchanged when both occur; pkt_pending[i] = (last-counter != 0).
REQ-023 link_out valid, once asserted, shall stay asserted with stable last/data until popped (except reset).
REQ-024 Flits arriving while link_in_ready is low shall be ignored and not stored.

Reset
REQ-025 While rst is high: count, pointers, last-counters = 0; link_out valid = 0; level = 0; pkt_pending = 0; link_in_ready = 0.
REQ-026 First edge with rst low shall set link_in_ready = 1 on both channels.
REQ-027 Reset mid-operation shall discard all stored flits; no partial packet emitted afterwards.
REQ-028 Storage array contents need not be reset.

Verification
REQ-029 Single flit ch0 {last=1, data=16'hA5A5}, link_out_ready=1 -> link_out[0] valid with 16'hA5A5, last=1 exactly one cycle after acceptance; pkt_pending[0] pulses 1 cycle; level returns 0.
REQ-030 DEPTH=4, link_out_ready[1]=0, push 6 flits -> 4 accepted, link_in_ready[1]=0, level[1]=4; release ready -> data 0..3 emitted in order, ready returns the cycle after first pop.
REQ-031 Continuous push/pop on both channels for 20 cycles with random link_out_ready -> output sequence equals input sequence per channel, pointer wrap exercised, no loss.
REQ-032 Full FIFO with push attempted and pop on same cycle -> pushed flit not stored (ready was 0), level goes 4->3.
REQ-033 Two 3-flit packets stored, downstream stalled -> pkt_pending=1, level=6 (DEPTH=8); pop first packet -> pkt_pending stays 1; pop second -> 0.
REQ-034 Assert rst with 3 flits stored -> next cycle level=0, valid=0, link_in_ready=0; after release, ready=1 and no stale flit appears.

Source files
------------

// File: rtl/debug_ring_link.sv
`default_nettype none
// ============================================================================
// debug_ring_link : two independent DEPTH-deep flit FIFOs between ring segments
// Rev 1.0
// ============================================================================
module debug_ring_link #(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0][17:0]            link_in,
  output logic [1:0]                  link_in_ready,
  output logic [1:0][17:0]            link_out,
  input  logic [1:0]                  link_out_ready,
  output logic [1:0][$clog2(DEPTH):0] level,
  output logic [1:0]                  pkt_pending
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  // Flit layout on both sides: {valid[17], last[16], data[15:0]}.
  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic [16:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [AW:0]   r_lastcnt;
    logic          r_in_rdy;
    logic [AW:0]   w_count_nxt;
    logic          w_push;
    logic          w_pop;
    logic          w_push_last;
    logic          w_pop_last;

    assign w_push      = link_in[g][17] && r_in_rdy;
    assign w_pop       = (r_count != '0) && link_out_ready[g];
    assign w_push_last = w_push && link_in[g][16];
    assign w_pop_last  = w_pop && r_mem[r_rptr][16];

    always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + 1'b1;
        2'b01:   w_count_nxt = r_count - 1'b1;
        default: w_count_nxt = r_count;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_wptr    <= '0;
        r_rptr    <= '0;
        r_count   <= '0;
        r_lastcnt <= '0;
        r_in_rdy  <= 1'b0;
      end else begin
        r_count  <= w_count_nxt;
        // Registered from next-count so downstream ready never reaches upstream ready.
        r_in_rdy <= (w_count_nxt < C_DEPTH);
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        case ({w_push_last, w_pop_last})
          2'b10:   r_lastcnt <= r_lastcnt + 1'b1;
          2'b01:   r_lastcnt <= r_lastcnt - 1'b1;
          default: r_lastcnt <= r_lastcnt;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= link_in[g][16:0];
    end

    assign link_in_ready[g] = r_in_rdy;
    assign link_out[g]      = {(r_count != '0), r_mem[r_rptr]};
    assign level[g]         = r_count;
    assign pkt_pending[g]   = (r_lastcnt != '0);
  end

endmodule
`default_nettype wire

// File: tb/tb_debug_ring_link.sv
`default_nettype none
// ============================================================================
// tb_debug_ring_link : queue-model bench driving a DEPTH=4 and a DEPTH=8 copy
// Rev 1.0
// ============================================================================
module tb_debug_ring_link;

  localparam int CAPA = 4;
  localparam int CAPB = 8;

  logic            clk;
  logic            rst;
  logic [1:0][17:0] link_in;
  logic [1:0]      out_rdy;

  logic [1:0]       a_in_rdy, b_in_rdy;
  logic [1:0][17:0] a_out, b_out;
  logic [1:0][2:0]  a_level;
  logic [1:0][3:0]  b_level;
  logic [1:0]       a_pend, b_pend;

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 0;

  debug_ring_link #(.DEPTH(CAPA)) u_dut_a (
    .clk(clk), .rst(rst), .link_in(link_in), .link_in_ready(a_in_rdy),
    .link_out(a_out), .link_out_ready(out_rdy), .level(a_level), .pkt_pending(a_pend)
  );

  debug_ring_link #(.DEPTH(CAPB)) u_dut_b (
    .clk(clk), .rst(rst), .link_in(link_in), .link_in_ready(b_in_rdy),
    .link_out(b_out), .link_out_ready(out_rdy), .level(b_level), .pkt_pending(b_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: one queue per (instance, channel), index = inst*2 + ch.
  logic [16:0] q [4][$];
  bit          m_rdy [4];

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        q[k].delete();
        m_rdy[k] = 1'b0;
      end else begin
        bit pu, po;
        pu = link_in[k%2][17] && m_rdy[k];
        po = (q[k].size() != 0) && out_rdy[k%2];
        if (po) void'(q[k].pop_front());
        if (pu) q[k].push_back(link_in[k%2][16:0]);
        m_rdy[k] = q[k].size() < ((k < 2) ? CAPA : CAPB);
      end
    end
  end

  function automatic bit model_pend(input int k);
    for (int i = 0; i < q[k].size(); i++)
      if (q[k][i][16]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input int k, input logic rdy, input logic [17:0] fl,
                     input logic [3:0] lvl, input logic pend);
    string p;
    p = $sformatf("m%0d.ch%0d", k/2, k%2);
    chk({p, ".ready"},   32'(rdy),       32'(m_rdy[k]));
    chk({p, ".valid"},   32'(fl[17]),    32'(q[k].size() != 0));
    if (q[k].size() != 0)
      chk({p, ".flit"},  32'(fl[16:0]),  32'(q[k][0]));
    chk({p, ".level"},   32'(lvl),       32'(q[k].size()));
    chk({p, ".pending"}, 32'(pend),      32'(model_pend(k)));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < 2; c++) begin
        cmp(c,     a_in_rdy[c], a_out[c], {1'b0, a_level[c]}, a_pend[c]);
        cmp(2 + c, b_in_rdy[c], b_out[c], b_level[c],         b_pend[c]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst     = 1'b1;
    link_in = '0;
    out_rdy = 2'b11;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sample();
    chk_en = 1'b1;
    chk("rst.ready", 32'(a_in_rdy), 32'd0);
    chk("rst.valid", 32'({a_out[1][17], a_out[0][17]}), 32'd0);
    chk("rst.level", 32'(a_level), 32'd0);
    chk("rst.pend",  32'(a_pend), 32'd0);
    step();
    sample();
    chk("first.ready", 32'(a_in_rdy), 32'd3);

    // Single last flit through channel 0.
    link_in[0] = {1'b1, 1'b1, 16'hA5A5};
    step();
    link_in[0] = '0;
    sample();
    chk("single.flit",  32'(a_out[0]), 32'h3A5A5);
    chk("single.pend",  32'(a_pend[0]), 32'd1);
    chk("single.level", 32'(a_level[0]), 32'd1);
    step();
    sample();
    chk("single.empty", 32'(a_out[0][17]), 32'd0);
    chk("single.pend0", 32'(a_pend[0]), 32'd0);
    chk("single.lvl0",  32'(a_level[0]), 32'd0);

    // Fill channel 1 with 6 attempts while stalled.
    out_rdy = 2'b01;
    for (int k = 0; k < 6; k++) begin
      link_in[1] = {1'b1, 1'b0, 16'(k)};
      step();
    end
    link_in[1] = '0;
    sample();
    chk("full.level", 32'(a_level[1]), 32'd4);
    chk("full.ready", 32'(a_in_rdy[1]), 32'd0);
    chk("full.b_lvl", 32'(b_level[1]), 32'd6);
    out_rdy = 2'b11;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain.d%0d", k), 32'(a_out[1]), 32'h20000 | 32'(k));
      if (k == 0) chk("drain.rdy0", 32'(a_in_rdy[1]), 32'd0);
      if (k == 1) chk("drain.rdy1", 32'(a_in_rdy[1]), 32'd1);
      step();
      sample();
    end
    chk("drain.empty", 32'(a_level[1]), 32'd0);
    repeat (4) step();

    // Full FIFO: push attempted on the same cycle as a pop.
    out_rdy = 2'b10;
    for (int k = 0; k < 4; k++) begin
      link_in[0] = {1'b1, 1'b0, 16'h0010 + 16'(k)};
      step();
    end
    link_in[0] = '0;
    sample();
    chk("pp.level4", 32'(a_level[0]), 32'd4);
    chk("pp.ready0", 32'(a_in_rdy[0]), 32'd0);
    link_in[0] = {1'b1, 1'b1, 16'hBEEF};
    out_rdy    = 2'b11;
    step();
    link_in[0] = '0;
    sample();
    chk("pp.level3", 32'(a_level[0]), 32'd3);
    chk("pp.head",   32'(a_out[0]), 32'h20011);
    chk("pp.ready1", 32'(a_in_rdy[0]), 32'd1);
    repeat (6) step();
    sample();
    chk("pp.empty", 32'(a_level[0]), 32'd0);

    // Two 3-flit packets into the DEPTH=8 copy.
    out_rdy = 2'b10;
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 3; k++) begin
        link_in[0] = {1'b1, (k == 2), 16'h0100 * 16'(p + 1) + 16'(k)};
        step();
      end
    link_in[0] = '0;
    sample();
    chk("pkt.b_lvl6",  32'(b_level[0]), 32'd6);
    chk("pkt.b_pend",  32'(b_pend[0]), 32'd1);
    chk("pkt.a_lvl4",  32'(a_level[0]), 32'd4);
    out_rdy = 2'b11;
    repeat (3) step();
    out_rdy = 2'b10;
    sample();
    chk("pkt.b_pend1", 32'(b_pend[0]), 32'd1);
    chk("pkt.b_lvl3",  32'(b_level[0]), 32'd3);
    chk("pkt.b_head",  32'(b_out[0]), 32'h20200);
    out_rdy = 2'b11;
    repeat (3) step();
    sample();
    chk("pkt.b_pend0", 32'(b_pend[0]), 32'd0);
    chk("pkt.b_lvl0",  32'(b_level[0]), 32'd0);

    // Streaming with random downstream ready; pointers wrap several times.
    begin
      logic [15:0] seq [2];
      seq[0] = 16'h3000;
      seq[1] = 16'h4000;
      for (int n = 0; n < 20; n++) begin
        for (int c = 0; c < 2; c++) begin
          if ($urandom_range(0, 3) != 0) begin
            link_in[c] = {1'b1, 1'($urandom_range(0, 1)), seq[c]};
            seq[c]     = seq[c] + 16'd1;
          end else begin
            link_in[c] = '0;
          end
        end
        out_rdy = 2'($urandom_range(0, 3));
        step();
      end
    end
    link_in = '0;
    out_rdy = 2'b11;
    repeat (10) step();

    // Reset with flits stored.
    out_rdy = 2'b00;
    for (int k = 0; k < 3; k++) begin
      link_in[0] = {1'b1, 1'b0, 16'h5000 + 16'(k)};
      link_in[1] = {1'b1, 1'b0, 16'h6000 + 16'(k)};
      step();
    end
    link_in = '0;
    sample();
    chk("rst2.pre", 32'(a_level[0]), 32'd3);
    rst = 1'b1;
    step();
    sample();
    chk("rst2.level", 32'(a_level), 32'd0);
    chk("rst2.valid", 32'({a_out[1][17], a_out[0][17]}), 32'd0);
    chk("rst2.ready", 32'(a_in_rdy), 32'd0);
    rst = 1'b0;
    step();
    sample();
    chk("rst2.ready1", 32'(a_in_rdy), 32'd3);
    out_rdy = 2'b11;
    for (int k = 0; k < 3; k++) begin
      step();
      sample();
      chk($sformatf("rst2.stale%0d", k), 32'({a_out[1][17], a_out[0][17]}), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
